// File: rtl/rx_link_buffer_if.sv
// rx_link_buffer_if: link-side and RX-FSM-side signals of the receive buffer
interface rx_link_buffer_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
);
   logic             in_valid;
   logic [31:0]      in_data;
   logic             credit_return;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic             out_sop;
   logic             out_eop;
   logic [CNT_W-1:0] count;
   logic             overflow_err;
   logic             err_clear;
   modport master (
      output in_valid, in_data, out_ready, err_clear,
      input  credit_return, out_valid, out_data, out_sop, out_eop, count, overflow_err
   );
   modport slave (
      input  in_valid, in_data, out_ready, err_clear,
      output credit_return, out_valid, out_data, out_sop, out_eop, count, overflow_err
   );
endinterface

// File: rtl/rx_link_buffer.sv
// rx_link_buffer: credit-governed link RX FIFO with packet framing on the head flit
module rx_link_buffer #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input logic        clk,
   input logic        n_rst,
   rx_link_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {HDR, PAYLOAD} state_t;
   logic [31:0]      mem_q [DEPTH];
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d, pend_q, pend_d;
   state_t           state_q, state_d;
   logic [7:0]       rem_q, rem_d;
   logic             ovf_q, ovf_d, credit_q, credit_d;
   logic             pop, push;
   assign bus.out_valid     = count_q != '0;
   assign pop               = bus.out_valid & bus.out_ready;
   assign push              = bus.in_valid & ((count_q < CNT_W'(DEPTH)) | pop);
   assign bus.out_data      = mem_q[head_q];
   assign bus.count         = count_q;
   assign bus.overflow_err  = ovf_q;
   assign bus.credit_return = credit_q;
   // FIFO pointers, occupancy, sticky overflow and credit bookkeeping
   always_comb begin
      head_d   = head_q + AW'(pop);
      tail_d   = tail_q + AW'(push);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      ovf_d    = (bus.in_valid & ~push) | (ovf_q & ~bus.err_clear);
      credit_d = pend_q != '0;
      pend_d   = pend_q - CNT_W'(credit_d) + CNT_W'(pop);
   end
   // framing FSM: header LEN byte sets how many payload flits follow
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      bus.out_sop = bus.out_valid & (state_q == HDR);
      bus.out_eop = bus.out_valid & ((state_q == HDR) ? (bus.out_data[7:0] == 8'd0) : (rem_q == 8'd1));
      if (pop) begin
         if (state_q == HDR) begin
            rem_d   = bus.out_data[7:0];
            state_d = (bus.out_data[7:0] != 8'd0) ? PAYLOAD : HDR;
         end else begin
            rem_d   = rem_q - 8'd1;
            state_d = (rem_q == 8'd1) ? HDR : PAYLOAD;
         end
      end
   end
   // control state; pending starts at DEPTH so the link learns the full buffer size
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         pend_q   <= CNT_W'(DEPTH);
         credit_q <= 1'b0;
         ovf_q    <= 1'b0;
         state_q  <= HDR;
         rem_q    <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         credit_q <= credit_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         rem_q    <= rem_d;
      end
   end
   // flit storage, deliberately left unreset
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= bus.in_data;
   end
endmodule
